muldiv_seq: RTL and testbench

- Iterative sequencer for the RV32M multiply/divide operations; replaces the single-cycle combinational multiplier and divider in the core ALU path.
- Accepts one operation over a valid/ready request handshake and runs a shift-add multiplier or a restoring divider for 32/UNROLL cycles.
- Returns the result over a valid/ready response handshake.
- Sits beside the ALU in the execute stage. The core stalls on req_ready_o / resp_valid_o.

---
 rtl/muldiv_seq.sv | 138 +++++++++++++
 tb/tb_muldiv_seq.sv | 180 ++++++++++++++++++
 2 files changed

// File: rtl/muldiv_seq.sv
// rtl/muldiv_seq.sv - iterative RV32M multiply/divide sequencer
// Shift-add multiplier and restoring divider on operand magnitudes, signs applied in FIXUP.
module muldiv_seq #(
  parameter int UNROLL = 1
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic [2:0]  op_i,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  input  logic        kill_i,
  output logic        resp_valid_o,
  input  logic        resp_ready_i,
  output logic [31:0] result_o,
  output logic        busy_o
);

  typedef enum logic [1:0] {IDLE, CALC, FIXUP, DONE} state_t;

  localparam logic [5:0] STEPS = 6'(32 / UNROLL);

  state_t      state, state_nx;
  logic [2:0]  op_q;
  logic        neg_q, neg_r;
  logic [63:0] acc, acc_step;
  logic [31:0] opnd;
  logic [5:0]  cnt;
  logic [31:0] result_q;

  logic        accept, a_signed, b_signed, a_neg, b_neg;
  logic        div_zero, div_ovf, fast;
  logic [31:0] a_mag, b_mag, fast_result, fix_result, quot, rem;
  logic [63:0] prod;
  logic [32:0] part;

  assign req_ready_o  = (state == IDLE) & ~kill_i;
  assign accept       = req_valid_i & req_ready_o;
  assign resp_valid_o = (state == DONE);
  assign busy_o       = (state != IDLE);
  assign result_o     = result_q;

  // funct3: bit 2 selects divide, bit 0 marks the unsigned divide variants
  assign a_signed = op_i[2] ? ~op_i[0] : (op_i[1:0] != 2'b11);
  assign b_signed = op_i[2] ? ~op_i[0] : ~op_i[1];
  assign a_neg    = a_signed & a_i[31];
  assign b_neg    = b_signed & b_i[31];
  assign a_mag    = a_neg ? -a_i : a_i;
  assign b_mag    = b_neg ? -b_i : b_i;

  assign div_zero = op_i[2] & (b_i == 32'd0);
  assign div_ovf  = op_i[2] & ~op_i[0] & (a_i == 32'h8000_0000) & (b_i == 32'hFFFF_FFFF);
  assign fast     = div_zero | div_ovf;

  always_comb begin
    fast_result = 32'h8000_0000;
    if (op_i[1]) fast_result = div_zero ? a_i : 32'd0;
    else if (div_zero) fast_result = 32'hFFFF_FFFF;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) state <= IDLE;
    else         state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (kill_i) begin
      state_nx = IDLE;
    end else begin
      case (state)
        IDLE:    if (accept) state_nx = fast ? DONE : CALC;
        CALC:    if (cnt == 6'd0) state_nx = FIXUP;
        FIXUP:   state_nx = DONE;
        DONE:    if (resp_ready_i) state_nx = IDLE;
        default: state_nx = IDLE;
      endcase
    end
  end

  // Divide keeps {remainder, dividend/quotient} in acc; multiply keeps {partial, multiplier}.
  always_comb begin
    acc_step = acc;
    part     = '0;
    for (int k = 0; k < UNROLL; k++) begin
      if (op_q[2]) begin
        part = acc_step[63:31] - {1'b0, opnd};
        if (!part[32]) acc_step = {part[31:0], acc_step[30:0], 1'b1};
        else           acc_step = {acc_step[62:0], 1'b0};
      end else begin
        part     = {1'b0, acc_step[63:32]} + (acc_step[0] ? {1'b0, opnd} : 33'd0);
        acc_step = {part, acc_step[31:1]};
      end
    end
  end

  assign prod = neg_q ? -acc : acc;
  assign quot = neg_q ? -acc[31:0] : acc[31:0];
  assign rem  = neg_r ? -acc[63:32] : acc[63:32];

  always_comb begin
    fix_result = prod[63:32];
    if (op_q[2])                fix_result = op_q[1] ? rem : quot;
    else if (op_q[1:0] == 2'b00) fix_result = prod[31:0];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      op_q     <= '0;
      neg_q    <= 1'b0;
      neg_r    <= 1'b0;
      acc      <= '0;
      opnd     <= '0;
      cnt      <= '0;
      result_q <= '0;
    end else if (!kill_i) begin
      case (state)
        IDLE: if (accept) begin
          op_q  <= op_i;
          neg_q <= a_neg ^ b_neg;
          neg_r <= a_neg;
          cnt   <= STEPS;
          opnd  <= op_i[2] ? b_mag : a_mag;
          acc   <= {32'd0, op_i[2] ? a_mag : b_mag};
          if (fast) result_q <= fast_result;
        end
        CALC: if (cnt != 6'd0) begin
          acc <= acc_step;
          cnt <= cnt - 6'd1;
        end
        FIXUP:   result_q <= fix_result;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// tb/tb_muldiv_seq.sv - directed self-checking bench for muldiv_seq
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        rst_n, req_valid, req_ready, kill, resp_valid, resp_ready, busy;
  logic [2:0]  op;
  logic [31:0] a, b, result;
  int          total = 0;
  int          bad = 0;

  always #5 clk = ~clk;

  muldiv_seq #(.UNROLL(1)) dut (
    .clk_i(clk), .rst_ni(rst_n), .req_valid_i(req_valid), .req_ready_o(req_ready),
    .op_i(op), .a_i(a), .b_i(b), .kill_i(kill), .resp_valid_o(resp_valid),
    .resp_ready_i(resp_ready), .result_o(result), .busy_o(busy)
  );

  // lat = edges after the accept edge until resp_valid is seen high (100 = timeout)
  task automatic issue(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y, output int lat);
    @(negedge clk);
    op = o; a = x; b = y; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0; a = $urandom; b = $urandom; op = 3'($urandom);
    lat = 0;
    while (!resp_valid && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic release_resp;
    resp_ready = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_reset;
    repeat (2) @(posedge clk);
    #1;
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL reset_req_ready got=%b exp=1", req_ready); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL reset_resp_valid got=%b exp=0", resp_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL reset_result got=%h exp=0", result); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_mul;
    logic [2:0]  ops [4] = '{3'd0, 3'd1, 3'd2, 3'd3};
    logic [31:0] av  [4] = '{32'd7, 32'h8000_0000, 32'hFFFF_FFFF, 32'hFFFF_FFFF};
    logic [31:0] bv  [4] = '{32'hFFFF_FFFD, 32'h8000_0000, 32'd2, 32'd2};
    logic [31:0] ev  [4] = '{32'hFFFF_FFEB, 32'h4000_0000, 32'hFFFF_FFFF, 32'h0000_0001};
    int lat;
    for (int i = 0; i < 4; i++) begin
      issue(ops[i], av[i], bv[i], lat);
      total++; if (lat !== 34) begin bad++; $display("FAIL mul_latency[%0d] got=%0d exp=34", i, lat); end
      total++; if (result !== ev[i]) begin bad++; $display("FAIL mul_result[%0d] got=%h exp=%h", i, result, ev[i]); end
      release_resp;
      total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL mul_valid_fall[%0d] got=%b exp=0", i, resp_valid); end
    end
  endtask

  task automatic test_div;
    logic [2:0]  ops [6] = '{3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6};
    logic [31:0] av  [6] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd100, 32'd100, 32'd7, 32'd7};
    logic [31:0] bv  [6] = '{32'd2, 32'd2, 32'd7, 32'd7, 32'hFFFF_FFFE, 32'hFFFF_FFFE};
    logic [31:0] ev  [6] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'd14, 32'd2, 32'hFFFF_FFFD, 32'd1};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], av[i], bv[i], lat);
      total++; if (lat !== 34) begin bad++; $display("FAIL div_latency[%0d] got=%0d exp=34", i, lat); end
      total++; if (result !== ev[i]) begin bad++; $display("FAIL div_result[%0d] got=%h exp=%h", i, result, ev[i]); end
      release_resp;
    end
  endtask

  task automatic test_fast;
    logic [2:0]  ops [6] = '{3'd5, 3'd6, 3'd4, 3'd6, 3'd4, 3'd7};
    logic [31:0] av  [6] = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'hFFFF_FFF9, 32'hDEAD_BEEF};
    logic [31:0] bv  [6] = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
    logic [31:0] ev  [6] = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'hDEAD_BEEF};
    int lat;
    for (int i = 0; i < 6; i++) begin
      issue(ops[i], av[i], bv[i], lat);
      total++; if (lat !== 0) begin bad++; $display("FAIL fast_latency[%0d] got=%0d exp=0", i, lat); end
      total++; if (result !== ev[i]) begin bad++; $display("FAIL fast_result[%0d] got=%h exp=%h", i, result, ev[i]); end
      release_resp;
    end
  endtask

  task automatic test_backpressure;
    int lat;
    resp_ready = 1'b0;
    issue(3'd0, 32'd3, 32'd5, lat);
    @(negedge clk);
    op = 3'd5; a = 32'd5; b = 32'd0; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL bp_valid[%0d] got=%b exp=1", i, resp_valid); end
      total++; if (result !== 32'd15) begin bad++; $display("FAIL bp_result[%0d] got=%h exp=0000000f", i, result); end
      total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL bp_req_ready[%0d] got=%b exp=0", i, req_ready); end
    end
    @(negedge clk); resp_ready = 1'b1;
    @(posedge clk); #1;
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL bp_handshake_valid got=%b exp=0", resp_valid); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL bp_handshake_ready got=%b exp=1", req_ready); end
    @(posedge clk); #1;
    req_valid = 1'b0;
    total++; if (resp_valid !== 1'b1) begin bad++; $display("FAIL b2b_valid got=%b exp=1", resp_valid); end
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL b2b_result got=%h exp=ffffffff", result); end
    release_resp;
  endtask

  task automatic test_kill;
    int lat;
    bit seen;
    issue(3'd5, 32'd5, 32'd0, lat);
    release_resp;
    @(negedge clk);
    op = 3'd0; a = 32'd7; b = 32'd3; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    total++; if (busy !== 1'b1) begin bad++; $display("FAIL kill_busy_before got=%b exp=1", busy); end
    kill = 1'b1; #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL kill_req_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    kill = 1'b0;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_busy_after got=%b exp=0", busy); end
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL kill_no_resp got=%b exp=0", seen); end
    total++; if (result !== 32'hFFFF_FFFF) begin bad++; $display("FAIL kill_result_hold got=%h exp=ffffffff", result); end
    @(negedge clk);
    op = 3'd5; a = 32'd1; b = 32'd0; req_valid = 1'b1; kill = 1'b1;
    #1;
    total++; if (req_ready !== 1'b0) begin bad++; $display("FAIL kill_idle_ready got=%b exp=0", req_ready); end
    @(posedge clk); #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL kill_idle_busy got=%b exp=0", busy); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL kill_idle_valid got=%b exp=0", resp_valid); end
    @(negedge clk); req_valid = 1'b0; kill = 1'b0;
  endtask

  task automatic test_reset_mid;
    int lat;
    bit seen;
    @(negedge clk);
    op = 3'd0; a = 32'd9; b = 32'd9; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL rst_mid_busy got=%b exp=0", busy); end
    total++; if (resp_valid !== 1'b0) begin bad++; $display("FAIL rst_mid_valid got=%b exp=0", resp_valid); end
    total++; if (result !== 32'd0) begin bad++; $display("FAIL rst_mid_result got=%h exp=0", result); end
    total++; if (req_ready !== 1'b1) begin bad++; $display("FAIL rst_mid_ready got=%b exp=1", req_ready); end
    @(negedge clk); rst_n = 1'b1;
    seen = 1'b0;
    repeat (40) begin @(posedge clk); #1; if (resp_valid) seen = 1'b1; end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rst_mid_no_resp got=%b exp=0", seen); end
    issue(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, lat);
    total++; if (result !== 32'hFFFF_FFFE) begin bad++; $display("FAIL post_rst_mulhu got=%h exp=fffffffe", result); end
    release_resp;
  endtask

  initial begin
    rst_n = 1'b0; req_valid = 1'b0; kill = 1'b0; resp_ready = 1'b1;
    op = '0; a = '0; b = '0;
    test_reset;
    test_mul;
    test_div;
    test_fast;
    test_backpressure;
    test_kill;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
